// File: rtl/apb_master_bridge.sv
// Turns one valid/ready command into a single APB3 transfer and returns the result on a valid/ready response.
// Latency: zero-wait slave gives rsp_valid 4 cycles after accept; cmd_ready stays low until the response is taken.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      PADDR       <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_addr[1:0] != 2'b00) begin
              // Misaligned: answer locally, the bus (and its held PADDR/PWRITE) is left untouched.
              state       <= RESP;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_rdata   <= '0;
            end else begin
              state  <= SETUP;
              PSEL   <= 1'b1;
              PADDR  <= cmd_addr;
              PWRITE <= cmd_write;
              PWDATA <= cmd_wdata;
            end
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            // PREADY takes priority over an expiring counter in the same cycle.
            state       <= RESP;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
              state       <= RESP;
              PSEL        <= 1'b0;
              PENABLE     <= 1'b0;
              rsp_valid   <= 1'b1;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
              rsp_rdata   <= '0;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: small APB register slave model plus a response scoreboard.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  typedef struct packed {
    logic        err;
    logic        to;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    rsp_t        exp;
  } cmd_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic stall  = 1'b0;
  int   psel_cyc = 0;
  int   pen_cyc  = 0;
  logic [31:0] sregs [0:1] = '{32'h0, 32'h0};

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave: 0x0/0x4 read-write, 0x8 read-only mirror of 0x0, anything else errors.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PREADY  <= 1'b0;
      PRDATA  <= 32'h0;
      PSLVERR <= 1'b0;
    end else begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= 32'h0;
      if (PSEL && PENABLE && !PREADY && !stall) begin
        PREADY <= 1'b1;
        if (PADDR == 32'h0 || PADDR == 32'h4) begin
          if (PWRITE) begin
            sregs[PADDR[2]] <= PWDATA;
            PRDATA          <= 32'h55AA55AA;
          end else begin
            PRDATA <= sregs[PADDR[2]];
          end
        end else if (PADDR == 32'h8 && !PWRITE) begin
          PRDATA <= sregs[0];
        end else begin
          PSLVERR <= 1'b1;
          PRDATA  <= 32'hBAD0BAD0;
        end
      end
    end
  end

  always @(negedge PCLK) begin
    if (PSEL)    psel_cyc++;
    if (PENABLE) pen_cyc++;
  end

  function automatic cmd_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic err, input logic to, input logic [31:0] rd);
    cmd_t c;
    c.w = w; c.a = a; c.d = d;
    c.exp.err = err; c.exp.to = to; c.exp.rdata = rd;
    return c;
  endfunction

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  // Returns cycles from accept to rsp_valid, or -1 if it never came.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(negedge PCLK);
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    #12;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, PSEL, PENABLE, PWRITE} !== 8'h0 ||
        rsp_rdata !== 32'h0 || PADDR !== 32'h0 || PWDATA !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b rdata=%h paddr=%h pwdata=%h, want all zero",
               {cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, PSEL, PENABLE, PWRITE},
               rsp_rdata, PADDR, PWDATA);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: cmd_ready=%b busy=%b, want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic();
    cmd_t tbl [4];
    int   lat, p0, e0;
    rsp_t got, exp;
    tbl[0] = mk(1'b1, 32'h0, 32'h000000F0, 1'b0, 1'b0, 32'h0);
    tbl[1] = mk(1'b1, 32'h4, 32'h00000001, 1'b0, 1'b0, 32'h0);
    tbl[2] = mk(1'b0, 32'h8, 32'h0,        1'b0, 1'b0, 32'h000000F0);
    tbl[3] = mk(1'b0, 32'h4, 32'h0,        1'b0, 1'b0, 32'h00000001);
    for (int i = 0; i < 4; i++) begin
      p0 = psel_cyc; e0 = pen_cyc;
      sb.push_back(tbl[i].exp);
      send_cmd(tbl[i].w, tbl[i].a, tbl[i].d);
      checks++;
      if (PADDR !== tbl[i].a || PWRITE !== tbl[i].w || (tbl[i].w && PWDATA !== tbl[i].d)) begin
        errors++;
        $display("FAIL basic_bus[%0d]: paddr=%h pwrite=%b pwdata=%h, want %h %b %h",
                 i, PADDR, PWRITE, PWDATA, tbl[i].a, tbl[i].w, tbl[i].d);
      end
      wait_rsp(lat);
      got = {rsp_err, rsp_timeout, rsp_rdata};
      exp = sb.pop_front();
      ack_rsp();
      checks++;
      if (lat !== 4 || got !== exp) begin
        errors++;
        $display("FAIL basic_rsp[%0d]: lat=%0d err=%b to=%b rdata=%h, want lat=4 err=%b to=%b rdata=%h",
                 i, lat, got.err, got.to, got.rdata, exp.err, exp.to, exp.rdata);
      end
      checks++;
      if (psel_cyc - p0 !== 3 || pen_cyc - e0 !== 2) begin
        errors++;
        $display("FAIL basic_psel[%0d]: psel=%0d penable=%0d cycles, want 3 2",
                 i, psel_cyc - p0, pen_cyc - e0);
      end
    end
  endtask

  task automatic test_slave_error();
    cmd_t tbl [2];
    int   lat;
    rsp_t got, exp;
    tbl[0] = mk(1'b1, 32'h8, 32'h12345678, 1'b1, 1'b0, 32'h0);
    tbl[1] = mk(1'b0, 32'hC, 32'h0,        1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      sb.push_back(tbl[i].exp);
      send_cmd(tbl[i].w, tbl[i].a, tbl[i].d);
      wait_rsp(lat);
      got = {rsp_err, rsp_timeout, rsp_rdata};
      exp = sb.pop_front();
      ack_rsp();
      checks++;
      if (lat !== 4 || got !== exp) begin
        errors++;
        $display("FAIL slverr[%0d]: lat=%0d err=%b to=%b rdata=%h, want lat=4 err=%b to=%b rdata=%h",
                 i, lat, got.err, got.to, got.rdata, exp.err, exp.to, exp.rdata);
      end
    end
  endtask

  task automatic test_timeout();
    int   lat, p0, e0;
    rsp_t got, exp;
    stall = 1'b1;
    p0 = psel_cyc; e0 = pen_cyc;
    sb.push_back(rsp_t'{err: 1'b1, to: 1'b1, rdata: 32'h0});
    send_cmd(1'b0, 32'h0, 32'h0);
    wait_rsp(lat);
    got = {rsp_err, rsp_timeout, rsp_rdata};
    exp = sb.pop_front();
    checks++;
    if (lat !== 18 || got !== exp) begin
      errors++;
      $display("FAIL timeout_rsp: lat=%0d err=%b to=%b rdata=%h, want lat=18 err=%b to=%b rdata=%h",
               lat, got.err, got.to, got.rdata, exp.err, exp.to, exp.rdata);
    end
    checks++;
    if (psel_cyc - p0 !== 17 || pen_cyc - e0 !== 16 || PSEL !== 1'b0) begin
      errors++;
      $display("FAIL timeout_bus: psel=%0d penable=%0d cycles psel_now=%b, want 17 16 0",
               psel_cyc - p0, pen_cyc - e0, PSEL);
    end
    ack_rsp();
    stall = 1'b0;
  endtask

  task automatic test_hold();
    int   lat;
    rsp_t got, exp;
    sb.push_back(rsp_t'{err: 1'b0, to: 1'b0, rdata: 32'h00000001});
    send_cmd(1'b0, 32'h4, 32'h0);
    wait_rsp(lat);
    got = {rsp_err, rsp_timeout, rsp_rdata};
    exp = sb.pop_front();
    checks++;
    if (lat !== 4 || got !== exp) begin
      errors++;
      $display("FAIL hold_rsp: lat=%0d err=%b to=%b rdata=%h, want lat=4 err=%b to=%b rdata=%h",
               lat, got.err, got.to, got.rdata, exp.err, exp.to, exp.rdata);
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp.rdata || cmd_ready !== 1'b0 || PSEL !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: rsp_valid=%b rdata=%h cmd_ready=%b psel=%b, want 1 %h 0 0",
                 i, rsp_valid, rsp_rdata, cmd_ready, PSEL, exp.rdata);
      end
    end
    cmd_valid = 1'b0;
    ack_rsp();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: cmd_ready=%b rsp_valid=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] addrs [2];
    int   lat, p0;
    rsp_t got, exp;
    addrs[0] = 32'h2;
    addrs[1] = 32'h7;
    for (int i = 0; i < 2; i++) begin
      p0 = psel_cyc;
      sb.push_back(rsp_t'{err: 1'b1, to: 1'b0, rdata: 32'h0});
      send_cmd(i[0], addrs[i], 32'hCAFEF00D);
      wait_rsp(lat);
      got = {rsp_err, rsp_timeout, rsp_rdata};
      exp = sb.pop_front();
      ack_rsp();
      checks++;
      if (lat !== 1 || got !== exp || psel_cyc - p0 !== 0) begin
        errors++;
        $display("FAIL misaligned[%0d]: lat=%0d err=%b to=%b rdata=%h psel=%0d, want lat=1 err=1 to=0 rdata=0 psel=0",
                 i, lat, got.err, got.to, got.rdata, psel_cyc - p0);
      end
      checks++;
      if (PADDR !== 32'h4 || PWRITE !== 1'b0) begin
        errors++;
        $display("FAIL misaligned_hold[%0d]: paddr=%h pwrite=%b, want 00000004 0", i, PADDR, PWRITE);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   lat, seen;
    rsp_t got, exp;
    stall = 1'b1;
    send_cmd(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 20 && !PENABLE; i++) @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    checks++;
    if (PSEL !== 1'b0 || PENABLE !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: psel=%b penable=%b busy=%b, want 0 0 0", PSEL, PENABLE, busy);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    stall = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_norsp: rsp_valid seen %0d cycles, want 0", seen);
    end
    sb.push_back(rsp_t'{err: 1'b0, to: 1'b0, rdata: 32'h000000F0});
    send_cmd(1'b0, 32'h0, 32'h0);
    wait_rsp(lat);
    got = {rsp_err, rsp_timeout, rsp_rdata};
    exp = sb.pop_front();
    ack_rsp();
    checks++;
    if (lat !== 4 || got !== exp) begin
      errors++;
      $display("FAIL reset_recover: lat=%0d err=%b to=%b rdata=%h, want lat=4 err=%b to=%b rdata=%h",
               lat, got.err, got.to, got.rdata, exp.err, exp.to, exp.rdata);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    test_reset();
    test_basic();
    test_slave_error();
    test_timeout();
    test_hold();
    test_misaligned();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Upstream APB requester for the register slave: converts a simple valid/ready command stream (from bench sequencer or control FSM) into single APB3 transfers, then returns read data/status on a valid/ready response channel.
- One outstanding transfer at a time.
- Adds wait-state handling, a bus timeout and local rejection of misaligned addresses.

Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR.
- DATA_W, 32, width of write/read data.
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY=0 before abort (>=1).

Ports:
- PCLK  in  1  bus clock.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command this cycle.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_W  read data (0 for writes/errors).
- rsp_err  out  1  slave error, timeout or misaligned.
- rsp_timeout  out  1  error cause was timeout.
- busy  out  1  state != IDLE.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready (slave pulses it one cycle after PSEL&PENABLE).
- PSLVERR  in  1  APB error, sampled with PREADY.

Behaviour:
- One clock PCLK; reset PRESETn asynchronous, active-low. All outputs registered.
- Reset values: all outputs 0; FSM=IDLE; timeout counter 0. Reset asserted mid-transfer aborts immediately: PSEL/PENABLE drop asynchronously, and no response is produced for the aborted command.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch write/addr/wdata.
  - If cmd_addr[1:0]!=0: go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0. No bus activity.
  - Otherwise go to SETUP.
- SETUP (one cycle): PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA driven from latch. Next state ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA stable.
  - Counter increments each cycle PREADY=0.
  - PREADY=1: capture PRDATA (reads only, else 0) into rsp_rdata and PSLVERR into rsp_err. Clear PSEL/PENABLE on the next edge. Go to RESP.
  - Counter reaches TIMEOUT_CYCLES with PREADY still 0: clear PSEL/PENABLE; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Go to RESP.
  - PREADY=1 on the same cycle the counter would expire: PREADY wins, no timeout.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1.
  - On handshake: rsp_valid=0, counter cleared, IDLE.
  - cmd_ready=0 throughout (no command accepted while a response is pending).
- PADDR and PWRITE keep their last values while PSEL=0, changing only when entering SETUP; the slave's post-transfer display logic depends on this. PWDATA is treated the same way.
- PRDATA/PSLVERR are ignored outside ACCESS. A stray PREADY in IDLE/SETUP/RESP has no effect.
- Latency, zero-wait slave with 1-cycle registered PREADY, command accepted at edge T:
  - SETUP at T+1.
  - ACCESS at T+2 and T+3 (PREADY seen at T+3).
  - rsp_valid at T+4.
  - Earliest next accept: the cycle after the rsp handshake.
- busy=1 in SETUP/ACCESS/RESP.

Test Plan:
- Write 0x0 = 0x000000F0, write 0x4 = 0x00000001, read 0x8 -> three responses with rsp_err=0; read returns rsp_rdata=0x000000F0. PSEL high exactly 3 cycles per transfer.
- Write 0x8 = 0x12345678 -> rsp_err=1, rsp_timeout=0. Read 0xC -> rsp_err=1, rsp_rdata=0.
- PREADY tied 0, TIMEOUT_CYCLES=16, read 0x0 -> PSEL drops after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Read 0x4 with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0 throughout; after the handshake, cmd_ready=1 next cycle.
- Command addr 0x2 -> no PSEL assertion; rsp_err=1 one cycle after accept.
- PRESETn pulsed low during ACCESS -> PSEL/PENABLE=0 immediately, rsp_valid never asserts; the next command after reset completes normally.
